uart_tx_engine: RTL and testbench
=================================

Name: uart_tx_engine

Overview:
- Transmit serialiser directly downstream of the UART transmit FIFO.
- Pops bytes from the FIFO read port, one at a time, and shifts each out on the tx line as an asynchronous serial frame.
- Frame format: 1 start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
- Bit timing comes from a runtime clock divider, so the UART controller can change baud rate without re-synthesis.

Parameters:
- DIV_WIDTH, 16, width of the baud divider input and the internal bit-timer counter.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-low reset; sampled on the rising edge of clk, 0 = reset.
- enable  input  1  when 1, may start a new frame; a frame in progress always completes.
- baud_div  input  DIV_WIDTH  bit period minus one, in clk cycles; values below 3 are treated as 3.
- parity_en  input  1  when 1, insert a parity bit after the data bits.
- parity_odd  input  1  when 1, parity is odd; when 0, parity is even.
- two_stop  input  1  when 1, send 2 stop bits; when 0, send 1.
- fifo_empty  input  1  FIFO empty flag.
- fifo_read_data  input  8  FIFO head byte; valid 1 cycle after the FIFO read pointer settles.
- fifo_read_strobe  output  1  single-cycle pop pulse to the FIFO.
- tx  output  1  serial line; idles high.
- busy  output  1  high from FETCH through the end of the last stop bit.
- tx_done  output  1  single-cycle pulse at the end of the last stop bit.

Behaviour:
- Reset values (rst == 0 on a clock edge): tx = 1, busy = 0, tx_done = 0, fifo_read_strobe = 0, state = IDLE, all counters 0.
- Reset mid-frame aborts the frame immediately; tx returns high on the next edge. Any byte already popped is lost.
- Config latch: baud_div, parity_en, parity_odd and two_stop are captured into registers on the IDLE->FETCH transition. Changes mid-frame have no effect on that frame.
- State machine (one-hot or encoded, implementer's choice):
  - IDLE: if enable && !fifo_empty, go to FETCH.
  - FETCH: exactly 1 cycle; this is the BRAM read-latency wait. Go to LOAD.
  - LOAD: latch fifo_read_data into the shift register, pulse fifo_read_strobe for this one cycle, compute parity = ^data ^ parity_odd, load the bit timer, go to START.
  - START: tx = 0 for one bit period, then go to DATA.
  - DATA: tx = shift_reg[0]; shift right once per bit period; after 8 bits, go to PARITY if parity_en, else STOP.
  - PARITY: tx = the computed parity bit for one bit period, then go to STOP.
  - STOP: tx = 1 for 1 or 2 bit periods; at the end, pulse tx_done and go to IDLE.
- Bit timer: loaded with the effective divider; counts down to 0; the terminal count advances the bit. Each bit lasts exactly (effective baud_div + 1) clk cycles.
- tx is a registered output. It changes on the cycle after the state/bit transition, the same for every bit.
- Back-to-back frames: when returning to IDLE with enable high and fifo_empty low, FETCH starts on the next cycle.
  - Inter-frame gap = 3 cycles (IDLE, FETCH, LOAD), during which tx stays 1.
- fifo_read_strobe is never asserted while fifo_empty = 1, so the FIFO never sees an underflow from this block.
- enable deasserted mid-frame: the current frame completes, then the block stays in IDLE.
- fifo_empty rising during FETCH (FIFO reset or flush): abort to IDLE without a pop; busy drops.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding constants (IDLE, FETCH, LOAD, START, DATA, PARITY, STOP);
  - UART_DATA_BITS = 8;
  - UART_MIN_DIV = 3.
- One natural sub-module, uart_baud_timer: loadable down-counter with a terminal-count strobe, DIV_WIDTH wide.
  - The receive side reuses it at 16x oversample.

Test Plan:
- Reset: hold rst = 0 for 4 cycles with fifo_empty = 0 -> tx = 1, busy = 0, no fifo_read_strobe pulses.
- Single byte 0xA5, baud_div = 9, no parity, 1 stop:
  - exactly one fifo_read_strobe;
  - tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 10 cycles;
  - one tx_done pulse; busy high for 102 cycles.
- Parity: byte 0x03 with parity_en = 1:
  - parity_odd = 0 -> parity bit 0;
  - parity_odd = 1 -> parity bit 1.
- Two stop bits with back-to-back bytes 0x00, 0xFF, 0x55 in the FIFO:
  - three pops, each stop phase 2 bit periods;
  - 3-cycle idle-high gap between frames;
  - bytes in order.
- baud_div = 0 -> every bit lasts 4 cycles. Change baud_div to 19 mid-frame -> the current frame stays at 4 cycles per bit, the next frame uses 20.
- Reset mid-DATA (after bit 3 of 0x3C):
  - tx = 1 on the next edge; busy = 0; no tx_done;
  - after release, the next FIFO byte transmits normally.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions.
// Holds the transmit state encoding, the frame data width and the smallest
// divider the bit timer is allowed to run with.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_MIN_DIV   = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_START  = 3'd3,
    ST_DATA   = 3'd4,
    ST_PARITY = 3'd5,
    ST_STOP   = 3'd6
  } uart_state_t;

endpackage

// File: rtl/uart_baud_timer.sv
// Loadable down-counter producing one terminal-count strobe per period.
// Ports:
//   clk     - system clock
//   rst     - synchronous active-low reset
//   load    - force the counter to reload_value this cycle
//   run     - count down while high; reloads itself after reaching 0
//   reload  - period minus one, in clk cycles
//   tick    - high for the single cycle in which the count is 0 while running
module uart_baud_timer #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 run,
  input  logic [DIV_WIDTH-1:0] reload,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= reload;
    end else if (run) begin
      // Auto-reload keeps consecutive periods exactly reload+1 cycles long.
      if (count_reg == '0) count_reg <= reload;
      else                 count_reg <= count_reg - 1'b1;
    end
  end

  assign tick = run && (count_reg == '0);

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit serialiser sitting behind the transmit FIFO.
// Pops one byte at a time and sends start, 8 data bits LSB first, optional
// parity and 1 or 2 stop bits, with a runtime-programmable bit period.
// Ports:
//   clk, rst          - clock and synchronous active-low reset
//   enable            - permits starting a new frame
//   baud_div          - bit period minus one (values below 3 act as 3)
//   parity_en/odd     - parity insertion and sense
//   two_stop          - two stop bits when set
//   fifo_empty        - FIFO empty flag
//   fifo_read_data    - FIFO head byte
//   fifo_read_strobe  - one-cycle pop pulse
//   tx                - serial line, idles high
//   busy              - frame in progress (FETCH through last stop bit)
//   tx_done           - one-cycle pulse after the last stop bit
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 two_stop,
  input  logic                 fifo_empty,
  input  logic [7:0]           fifo_read_data,
  output logic                 fifo_read_strobe,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  uart_state_t          state_reg;
  logic [DIV_WIDTH-1:0] div_reg;
  logic                 parity_en_reg;
  logic                 parity_odd_reg;
  logic                 two_stop_reg;
  logic [7:0]           shift_reg;
  logic                 parity_reg;
  logic [2:0]           bit_cnt_reg;
  logic                 stop_cnt_reg;

  logic [DIV_WIDTH-1:0] div_eff;
  logic                 tick;
  logic                 timer_load;
  logic                 timer_run;

  assign div_eff = (baud_div < DIV_WIDTH'(UART_MIN_DIV)) ? DIV_WIDTH'(UART_MIN_DIV) : baud_div;

  // The timer is primed in LOAD so the first START cycle already counts.
  assign timer_load = (state_reg == ST_LOAD);
  assign timer_run  = (state_reg == ST_START) || (state_reg == ST_DATA) ||
                      (state_reg == ST_PARITY) || (state_reg == ST_STOP);

  uart_baud_timer #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_baud_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (timer_load),
    .run    (timer_run),
    .reload (div_reg),
    .tick   (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg        <= ST_IDLE;
      div_reg          <= '0;
      parity_en_reg    <= 1'b0;
      parity_odd_reg   <= 1'b0;
      two_stop_reg     <= 1'b0;
      shift_reg        <= '0;
      parity_reg       <= 1'b0;
      bit_cnt_reg      <= '0;
      stop_cnt_reg     <= 1'b0;
      fifo_read_strobe <= 1'b0;
      tx               <= 1'b1;
      busy             <= 1'b0;
      tx_done          <= 1'b0;
    end else begin
      fifo_read_strobe <= 1'b0;
      tx_done          <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (enable && !fifo_empty) begin
            // Frame configuration is frozen here for the whole frame.
            state_reg      <= ST_FETCH;
            busy           <= 1'b1;
            div_reg        <= div_eff;
            parity_en_reg  <= parity_en;
            parity_odd_reg <= parity_odd;
            two_stop_reg   <= two_stop;
          end
        end
        ST_FETCH: begin
          // Head byte settles during this cycle; a flush aborts without popping.
          if (fifo_empty) begin
            state_reg <= ST_IDLE;
            busy      <= 1'b0;
          end else begin
            state_reg        <= ST_LOAD;
            fifo_read_strobe <= 1'b1;
          end
        end
        ST_LOAD: begin
          shift_reg  <= fifo_read_data;
          parity_reg <= (^fifo_read_data) ^ parity_odd_reg;
          state_reg  <= ST_START;
          tx         <= 1'b0;
        end
        ST_START: begin
          if (tick) begin
            state_reg   <= ST_DATA;
            tx          <= shift_reg[0];
            shift_reg   <= {1'b0, shift_reg[7:1]};
            bit_cnt_reg <= '0;
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (bit_cnt_reg == 3'(UART_DATA_BITS - 1)) begin
              if (parity_en_reg) begin
                state_reg <= ST_PARITY;
                tx        <= parity_reg;
              end else begin
                state_reg    <= ST_STOP;
                tx           <= 1'b1;
                stop_cnt_reg <= 1'b0;
              end
            end else begin
              tx          <= shift_reg[0];
              shift_reg   <= {1'b0, shift_reg[7:1]};
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
            end
          end
        end
        ST_PARITY: begin
          if (tick) begin
            state_reg    <= ST_STOP;
            tx           <= 1'b1;
            stop_cnt_reg <= 1'b0;
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (two_stop_reg && !stop_cnt_reg) begin
              stop_cnt_reg <= 1'b1;
            end else begin
              state_reg <= ST_IDLE;
              busy      <= 1'b0;
              tx_done   <= 1'b1;
            end
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          tx        <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Scoreboard bench for uart_tx_engine: stimulus pushes expected frames,
// a monitor decodes the tx line and compares bit by bit.
module tb_uart_tx_engine;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [15:0] baud_div;
  logic        parity_en;
  logic        parity_odd;
  logic        two_stop;
  logic        fifo_empty;
  logic [7:0]  fifo_read_data;
  logic        fifo_read_strobe;
  logic        tx;
  logic        busy;
  logic        tx_done;

  uart_tx_engine #(.DIV_WIDTH(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .enable           (enable),
    .baud_div         (baud_div),
    .parity_en        (parity_en),
    .parity_odd       (parity_odd),
    .two_stop         (two_stop),
    .fifo_empty       (fifo_empty),
    .fifo_read_data   (fifo_read_data),
    .fifo_read_strobe (fifo_read_strobe),
    .tx               (tx),
    .busy             (busy),
    .tx_done          (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         period;
    bit         par_en;
    bit         par;
    bit         two;
    bit         chk_gap;
  } exp_t;

  exp_t exp_q[$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int strobe_cnt = 0;
  int done_cnt = 0;
  int underflow_cnt = 0;
  int busy_run = 0;
  int last_busy_len = 0;
  int done_cyc = 0;
  bit mon_off = 1'b0;
  bit mon_busy = 1'b0;

  // FIFO model
  logic [7:0] fifo_mem [0:15];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty     = (wr_ptr == rd_ptr);
  assign fifo_read_data = fifo_mem[rd_ptr[3:0]];

  initial begin
    forever begin
      @(posedge clk);
      if (fifo_read_strobe) begin
        if (fifo_empty) underflow_cnt = underflow_cnt + 1;
        rd_ptr <= rd_ptr + 1;
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(negedge clk);
      if (fifo_read_strobe) strobe_cnt = strobe_cnt + 1;
      if (tx_done) done_cnt = done_cnt + 1;
      if (busy) busy_run = busy_run + 1;
      else if (busy_run != 0) begin
        last_busy_len = busy_run;
        busy_run = 0;
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    vectors = vectors + 1;
    if (act != req) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic push_byte(input logic [7:0] d);
    fifo_mem[wr_ptr[3:0]] = d;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic expect_frame(input logic [7:0] d, input int p, input bit pe,
                              input bit pb, input bit ts, input bit gap);
    exp_t e;
    e.data = d; e.period = p; e.par_en = pe; e.par = pb; e.two = ts; e.chk_gap = gap;
    exp_q.push_back(e);
  endtask

  // Monitor: decodes one frame per start bit seen on tx.
  task automatic run_frame(input exp_t e);
    logic bits [0:11];
    int   nb;
    bit   bad;
    logic badv;
    int   start_cyc;
    start_cyc = cyc;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = e.data[i];
    nb = 9;
    if (e.par_en) begin bits[nb] = e.par; nb = nb + 1; end
    bits[nb] = 1'b1; nb = nb + 1;
    if (e.two) begin bits[nb] = 1'b1; nb = nb + 1; end
    if (e.chk_gap) check("interframe_gap", start_cyc - done_cyc, 3);
    for (int b = 0; b < nb; b++) begin
      bad = 1'b0;
      badv = bits[b];
      for (int c = 0; c < e.period; c++) begin
        if (!(b == 0 && c == 0)) @(negedge clk);
        if (tx !== bits[b]) begin bad = 1'b1; badv = tx; end
      end
      vectors = vectors + 1;
      if (bad) begin
        miscompares = miscompares + 1;
        $display("FAIL frame 0x%02h bit%0d: tx=%b, expected %b for %0d cycles",
                 e.data, b, badv, bits[b], e.period);
      end
    end
    @(negedge clk);
    check("tx_done_after_stop", int'(tx_done), 1);
    done_cyc = cyc;
    $display("frame data=0x%02h period=%0d parity_en=%0d two_stop=%0d checked",
             e.data, e.period, e.par_en, e.two);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!mon_off && rst && tx == 1'b0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_frame_start", 1, 0);
          while (tx == 1'b0) @(negedge clk);
        end else begin
          mon_busy = 1'b1;
          e = exp_q.pop_front();
          run_frame(e);
          mon_busy = 1'b0;
        end
      end
    end
  end

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      if (exp_q.size() == 0 && !mon_busy) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      check("drain_timeout", 0, 1);
      exp_q.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_tx_low(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (tx == 1'b0) begin ok = 1'b1; break; end
    end
  endtask

  initial begin
    int s0, d0;
    bit ok;
    rst = 1'b0; enable = 1'b1; baud_div = 16'd9;
    parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;

    // Reset held with a byte waiting
    @(negedge clk);
    push_byte(8'hA5);
    repeat (4) @(negedge clk);
    check("reset_tx", int'(tx), 1);
    check("reset_busy", int'(busy), 0);
    check("reset_strobes", strobe_cnt, 0);

    // 0xA5, 10-cycle bits, no parity, 1 stop
    expect_frame(8'hA5, 10, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    drain();
    check("a5_strobes", strobe_cnt, 1);
    check("a5_tx_done", done_cnt, 1);
    check("a5_busy_len", last_busy_len, 102);

    // Parity on 0x03, even then odd
    parity_en = 1'b1; parity_odd = 1'b0; baud_div = 16'd4;
    expect_frame(8'h03, 5, 1'b1, 1'b0, 1'b0, 1'b0);
    push_byte(8'h03);
    drain();
    parity_odd = 1'b1;
    expect_frame(8'h03, 5, 1'b1, 1'b1, 1'b0, 1'b0);
    push_byte(8'h03);
    drain();
    check("parity_busy_len", last_busy_len, 2 + 11 * 5);

    // Back-to-back with two stop bits
    parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b1;
    s0 = strobe_cnt;
    expect_frame(8'h00, 5, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_frame(8'hFF, 5, 1'b0, 1'b0, 1'b1, 1'b1);
    expect_frame(8'h55, 5, 1'b0, 1'b0, 1'b1, 1'b1);
    push_byte(8'h00); push_byte(8'hFF); push_byte(8'h55);
    drain();
    check("b2b_strobes", strobe_cnt - s0, 3);

    // Minimum divider, then baud change mid-frame
    two_stop = 1'b0; baud_div = 16'd0;
    expect_frame(8'h5A, 4, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_frame(8'hC3, 20, 1'b0, 1'b0, 1'b0, 1'b1);
    push_byte(8'h5A); push_byte(8'hC3);
    wait_tx_low(ok);
    check("div0_frame_started", int'(ok), 1);
    repeat (10) @(negedge clk);
    baud_div = 16'd19;
    drain();

    // Reset during data bit 4 of 0x3C
    baud_div = 16'd9;
    mon_off = 1'b1;
    s0 = strobe_cnt; d0 = done_cnt;
    push_byte(8'h3C);
    wait_tx_low(ok);
    check("abort_frame_started", int'(ok), 1);
    repeat (10 + 40 + 3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_tx", int'(tx), 1);
    check("abort_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("abort_no_tx_done", done_cnt - d0, 0);
    check("abort_one_pop", strobe_cnt - s0, 1);
    mon_off = 1'b0;
    expect_frame(8'h81, 10, 1'b0, 1'b0, 1'b0, 1'b0);
    push_byte(8'h81);
    drain();
    check("after_abort_tx_done", done_cnt - d0, 1);
    check("no_underflow", underflow_cnt, 0);
    check("fifo_empty_at_end", int'(fifo_empty), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
